// File: rtl/typing_round_ctrl.sv
// ============================================================================
// Module   : typing_round_ctrl
// Brief    : Typing-game round controller: LFSR target letters, hit/miss
//            scoring and a seconds countdown that ends the round.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module typing_round_ctrl #(
  parameter int         ROUND_SEC = 60,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [7:0] key_asc,
  output logic [7:0] target_asc,
  output logic       target_valid,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt,
  output logic [6:0] time_left,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [6:0] ROUND_TL = 7'(ROUND_SEC);
  localparam logic [7:0] CNT_MAX  = 8'hFF;
  localparam logic [7:0] ASC_A    = 8'h61;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] lfsr;
  logic [7:0] lfsr_step;
  logic [4:0] lfsr_v;
  logic [7:0] next_letter;
  logic       in_round;
  logic       idle_or_done;
  logic       start_ok;
  logic       final_tick;
  logic       key_hit;
  logic       key_miss;

  // Fibonacci LFSR, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1): maximal length, never hits 0
  assign lfsr_step    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign lfsr_v       = lfsr_step[4:0];
  assign next_letter  = (lfsr_v < 5'd26) ? (ASC_A + {3'b000, lfsr_v})
                                         : (ASC_A + {3'b000, lfsr_v - 5'd26});

  assign in_round     = (state == S_LOAD) || (state == S_WAIT);
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_ok     = idle_or_done && start;
  assign final_tick   = in_round && tick_1hz && (time_left == 7'd1);
  assign key_hit      = (state == S_WAIT) && key_valid && (key_asc == target_asc);
  assign key_miss     = (state == S_WAIT) && key_valid && (key_asc != target_asc);

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: the final tick takes priority over a hit's return to LOAD
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = final_tick ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (final_tick)   state_nxt = S_DONE;
        else if (key_hit) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    target_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_LOAD: busy = 1'b1;
      S_WAIT: begin
        busy         = 1'b1;
        target_valid = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lfsr       <= LFSR_SEED;
      target_asc <= 8'h00;
    end else if (state == S_LOAD) begin
      lfsr       <= lfsr_step;
      target_asc <= next_letter;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hit_cnt  <= 8'h00;
      miss_cnt <= 8'h00;
    end else if (start_ok) begin
      hit_cnt  <= 8'h00;
      miss_cnt <= 8'h00;
    end else begin
      if (key_hit && (hit_cnt != CNT_MAX))   hit_cnt  <= hit_cnt + 8'd1;
      if (key_miss && (miss_cnt != CNT_MAX)) miss_cnt <= miss_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      time_left <= ROUND_TL;
    end else if (start_ok) begin
      time_left <= ROUND_TL;
    end else if (in_round && tick_1hz && (time_left != 7'd0)) begin
      time_left <= time_left - 7'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_typing_round_ctrl.sv
// ============================================================================
// Module   : tb_typing_round_ctrl
// Brief    : Randomised self-checking bench for typing_round_ctrl against a
//            behavioural round model; two DUTs (60 s and 2 s rounds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_typing_round_ctrl;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_DONE = 3;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       start = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_asc = 8'h00;

  logic [7:0] ta0, h0, m0, ta1, h1, m1;
  logic       tv0, b0, d0, tv1, b1, d1;
  logic [6:0] tl0, tl1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  typing_round_ctrl dut0 (
    .clk(clk), .clrn(clrn), .start(start), .tick_1hz(tick_1hz),
    .key_valid(key_valid), .key_asc(key_asc),
    .target_asc(ta0), .target_valid(tv0), .hit_cnt(h0), .miss_cnt(m0),
    .time_left(tl0), .busy(b0), .done(d0)
  );

  typing_round_ctrl #(.ROUND_SEC(2)) dut1 (
    .clk(clk), .clrn(clrn), .start(start), .tick_1hz(tick_1hz),
    .key_valid(key_valid), .key_asc(key_asc),
    .target_asc(ta1), .target_valid(tv1), .hit_cnt(h1), .miss_cnt(m1),
    .time_left(tl1), .busy(b1), .done(d1)
  );

  // Behavioural round model, one entry per DUT
  int         m_ph  [2];
  int         m_tl  [2];
  int         m_hit [2];
  int         m_miss[2];
  logic [7:0] m_lf  [2];
  logic [7:0] m_tgt [2];

  function automatic int round_len(input int i);
    return (i == 0) ? 60 : 2;
  endfunction

  always @(posedge clk or negedge clrn) begin
    for (int i = 0; i < 2; i++) begin
      if (!clrn) begin
        m_ph[i] = PH_IDLE; m_tl[i] = round_len(i);
        m_hit[i] = 0; m_miss[i] = 0; m_lf[i] = 8'hA5; m_tgt[i] = 8'h00;
      end else if (m_ph[i] == PH_IDLE || m_ph[i] == PH_DONE) begin
        if (start) begin
          m_ph[i] = PH_LOAD; m_hit[i] = 0; m_miss[i] = 0; m_tl[i] = round_len(i);
        end
      end else begin
        automatic bit fin = tick_1hz && (m_tl[i] == 1);
        automatic int v;
        if (tick_1hz && m_tl[i] > 0) m_tl[i] = m_tl[i] - 1;
        if (m_ph[i] == PH_LOAD) begin
          m_lf[i]  = {m_lf[i][6:0], ^(m_lf[i] & 8'hB8)};
          v        = int'(m_lf[i]) % 32;
          m_tgt[i] = 8'(97 + ((v < 26) ? v : v - 26));
          m_ph[i]  = PH_WAIT;
        end else if (key_valid) begin
          if (key_asc == m_tgt[i]) begin
            if (m_hit[i] < 255) m_hit[i] = m_hit[i] + 1;
            m_ph[i] = PH_LOAD;
          end else if (m_miss[i] < 255) begin
            m_miss[i] = m_miss[i] + 1;
          end
        end
        if (fin) m_ph[i] = PH_DONE;
      end
    end
  end

  function automatic logic [33:0] exp_vec(input int i);
    return {m_tgt[i], m_ph[i] == PH_WAIT, 8'(m_hit[i]), 8'(m_miss[i]), 7'(m_tl[i]),
            (m_ph[i] == PH_LOAD) || (m_ph[i] == PH_WAIT), m_ph[i] == PH_DONE};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("cycle dut0", {ta0, tv0, h0, m0, tl0, b0, d0}, exp_vec(0));
    chk("cycle dut1", {ta1, tv1, h1, m1, tl1, b1, d1}, exp_vec(1));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    int budget;

    repeat (3) cyc();
    chk("reset target", ta0, 8'h00);
    chk("reset time", tl0, 7'd60);
    chk("reset flags", {tv0, b0, d0, h0, m0}, 0);
    clrn = 1'b1;
    cyc();

    // Start: one LOAD cycle, then first target from seed A5 -> 4A -> 'k'
    start = 1'b1; cyc(); start = 1'b0;
    chk("load busy", {b0, tv0}, 2'b10);
    cyc();
    chk("wait flags", {tv0, b0}, 2'b11);
    chk("first target", ta0, 8'h6B);
    chk("first time", tl0, 7'd60);

    key_valid = 1'b1; key_asc = 8'h6B; cyc(); key_valid = 1'b0;
    chk("hit count", h0, 8'd1);
    chk("hit load tv", tv0, 1'b0);
    cyc();
    chk("second target", {tv0, ta0}, {1'b1, 8'h76});

    // Uppercase of the target is a miss
    key_valid = 1'b1; key_asc = 8'h56; repeat (3) cyc(); key_valid = 1'b0;
    chk("miss count", m0, 8'd3);
    chk("miss target held", ta0, 8'h76);
    chk("miss hits held", h0, 8'd1);

    tick_1hz = 1'b1; cyc();
    chk("tick one", {tl1, tl0}, {7'd1, 7'd59});
    cyc(); tick_1hz = 1'b0;
    chk("tick final", {tl1, d1, b1, tl0}, {7'd0, 1'b1, 1'b0, 7'd58});

    key_valid = 1'b1; key_asc = 8'h76; cyc(); key_valid = 1'b0;
    chk("done ignores key", {h1, m1}, {8'd1, 8'd3});
    chk("busy dut still scores", h0, 8'd2);

    // Restart the short round; final tick coincides with a correct key
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("restart target", {ta1, tl1, h1, m1}, {8'h6B, 7'd2, 8'd0, 8'd0});
    tick_1hz = 1'b1; cyc();
    key_valid = 1'b1; key_asc = 8'h6B; cyc();
    tick_1hz = 1'b0; key_valid = 1'b0;
    chk("final tick hit", {h1, d1, b1, tl1}, {8'd1, 1'b1, 1'b0, 7'd0});
    cyc();
    chk("no load after final", {d1, b1, h1}, {1'b1, 1'b0, 8'd1});

    // 300 correct hits on the long round saturate hit_cnt
    n = 0; budget = 0;
    while (n < 300 && budget < 3000) begin
      if (m_ph[0] == PH_WAIT) begin
        key_valid = 1'b1; key_asc = m_tgt[0]; n++;
      end else begin
        key_valid = 1'b0;
      end
      cyc(); budget++;
    end
    key_valid = 1'b0;
    chk("hit loop budget", n, 300);
    cyc();
    chk("hit saturate", h0, 8'd255);

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      start     = ($urandom_range(0, 15) == 0);
      tick_1hz  = ($urandom_range(0, 7) == 0);
      key_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       key_asc = m_tgt[0];
        1:       key_asc = m_tgt[1];
        2:       key_asc = 8'(65 + $urandom_range(0, 25));
        default: key_asc = 8'(97 + $urandom_range(0, 25));
      endcase
      cyc();
    end
    start = 1'b0; tick_1hz = 1'b0; key_valid = 1'b0;

    // Reset mid-round acts immediately and leaves no residue
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    chk("pre-reset busy", b0, 1'b1);
    clrn = 1'b0;
    #1;
    chk("async reset dut0", {ta0, tv0, h0, m0, tl0, b0, d0},
        {8'h00, 1'b0, 8'd0, 8'd0, 7'd60, 1'b0, 1'b0});
    chk("async reset dut1", {ta1, tv1, h1, m1, tl1, b1, d1},
        {8'h00, 1'b0, 8'd0, 8'd0, 7'd2, 1'b0, 1'b0});
    cyc();
    clrn = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    chk("post-reset load", {b0, tv0}, 2'b10);
    cyc();
    chk("post-reset target", ta0, 8'h6B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
